layoutb_stream_ctrl: RTL and testbench

- Sequencer that feeds the skewed B-operand layout into the systolic array, one wavefront row per cycle.
- Takes the diagonal-skewed matrix produced by layoutB (OUTB, (2*DIM-1) rows x DIM columns) plus run dimensions n, p.
- Issues exactly n+p-1 wavefronts with a column mask, honours array back-pressure, waits a fixed drain period, then signals done.
- Sits between layoutB and the PE array input registers; accelerator top-level control drives start.

---
 rtl/layoutb_stream_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_layoutb_stream_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/layoutb_stream_ctrl.sv
//------------------------------------------------------------------------------
// Module      : layoutb_stream_ctrl
// Description : Streams the diagonal-skewed B-operand layout into the systolic
//               array one wavefront per cycle, with a column mask, stall
//               back-pressure, a fixed drain period and a done pulse.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module layoutb_stream_ctrl #(
  parameter int BITS  = 8,
  parameter int DIM   = 32,
  parameter int DRAIN = 32
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic [$clog2(DIM):0]                    n,
  input  logic [$clog2(DIM):0]                    p,
  input  logic [DIM*2-2:0][DIM-1:0][BITS-1:0]     OUTB,
  input  logic                                    stall,
  output logic                                    cap_en,
  output logic                                    row_valid,
  output logic [$clog2(2*DIM-1)-1:0]              row_idx,
  output logic [DIM-1:0][BITS-1:0]                row_data,
  output logic [DIM-1:0]                          col_mask,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    cfg_err
);

  localparam int NW = $clog2(DIM) + 1;      // width of n / p
  localparam int IW = $clog2(2*DIM-1);      // wavefront index width
  localparam int SW = $clog2(2*DIM);        // width of n_l + p_l - 2
  localparam int DW = $clog2(DRAIN+1);      // drain counter width

  // The drain phase starts in the cycle that presents the final wavefront, so
  // the counter runs one step further to leave DRAIN full cycles after it.
  localparam logic [DW-1:0] C_DRAIN_LAST = DW'(DRAIN);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nx;
  logic                       w_cfg_ok;
  logic                       w_cfg_bad;
  logic                       w_issue;
  logic                       w_at_last;
  logic [SW-1:0]              w_last;
  logic [DIM-1:0]             w_mask;
  logic [DIM-1:0][BITS-1:0]   w_row;

  logic [NW-1:0]              r_nl;
  logic [NW-1:0]              r_pl;
  logic [IW-1:0]              r_idx;
  logic [DW-1:0]              r_dcnt;
  logic                       r_cap_en;
  logic                       r_row_valid;
  logic [IW-1:0]              r_row_idx;
  logic [DIM-1:0][BITS-1:0]   r_row_data;
  logic [DIM-1:0]             r_col_mask;
  logic                       r_busy;
  logic                       r_done;
  logic                       r_cfg_err;

  assign w_cfg_ok  = (n >= NW'(1)) && (n <= NW'(DIM)) && (p >= NW'(1)) && (p <= NW'(DIM));
  assign w_last    = SW'(r_nl) + SW'(r_pl) - SW'(2);
  assign w_at_last = (SW'(r_idx) == w_last);
  assign w_issue   = (r_state == S_STREAM) && !stall;

  // Column mask from the requested p, latched at the start of a run.
  always_comb begin
    w_mask = '0;
    for (int c = 0; c < DIM; c++) begin
      w_mask[c] = (c < int'(p));
    end
  end

  // Current wavefront with columns outside the run forced to zero.
  always_comb begin
    w_row = '0;
    for (int c = 0; c < DIM; c++) begin
      if (r_col_mask[c]) begin
        w_row[c] = OUTB[r_idx][c];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state logic and illegal-configuration detection.
  always_comb begin
    w_state_nx = r_state;
    w_cfg_bad  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_cfg_ok) begin
            w_state_nx = S_LOAD;
          end else begin
            w_cfg_bad = 1'b1;
          end
        end
      end
      S_LOAD:   w_state_nx = S_STREAM;
      S_STREAM: begin
        if (w_issue && w_at_last) begin
          w_state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_dcnt == C_DRAIN_LAST) begin
          w_state_nx = S_DONE;
        end
      end
      S_DONE:   w_state_nx = S_IDLE;
      default:  w_state_nx = S_IDLE;
    endcase
  end

  // Datapath registers and registered outputs; status outputs track the
  // state being entered so they line up with the state cycle itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_nl        <= '0;
      r_pl        <= '0;
      r_idx       <= '0;
      r_dcnt      <= '0;
      r_cap_en    <= 1'b0;
      r_row_valid <= 1'b0;
      r_row_idx   <= '0;
      r_row_data  <= '0;
      r_col_mask  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_cap_en    <= (w_state_nx == S_LOAD);
      r_busy      <= (w_state_nx != S_IDLE);
      r_done      <= (w_state_nx == S_DONE);
      r_cfg_err   <= w_cfg_bad;
      r_row_valid <= w_issue;

      if ((r_state == S_IDLE) && start && w_cfg_ok) begin
        r_nl       <= n;
        r_pl       <= p;
        r_col_mask <= w_mask;
      end

      if (r_state == S_LOAD) begin
        r_idx <= '0;
      end

      if (w_issue) begin
        r_row_idx  <= r_idx;
        r_row_data <= w_row;
        r_idx      <= r_idx + IW'(1);
        if (w_at_last) begin
          r_dcnt <= '0;
        end
      end

      if (r_state == S_DRAIN) begin
        r_dcnt <= r_dcnt + DW'(1);
      end
    end
  end

  assign cap_en    = r_cap_en;
  assign row_valid = r_row_valid;
  assign row_idx   = r_row_idx;
  assign row_data  = r_row_data;
  assign col_mask  = r_col_mask;
  assign busy      = r_busy;
  assign done      = r_done;
  assign cfg_err   = r_cfg_err;

endmodule

`default_nettype wire

// File: tb/tb_layoutb_stream_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_layoutb_stream_ctrl
// Description : Directed self-checking bench for layoutb_stream_ctrl
//               (DIM=32, DRAIN=4).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_layoutb_stream_ctrl;

  localparam int BITS    = 8;
  localparam int DIM     = 32;
  localparam int DRAIN_C = 4;

  logic                                 clk = 1'b0;
  logic                                 rst;
  logic                                 start;
  logic [5:0]                           n;
  logic [5:0]                           p;
  logic [DIM*2-2:0][DIM-1:0][BITS-1:0]  OUTB;
  logic                                 stall;
  logic                                 cap_en;
  logic                                 row_valid;
  logic [5:0]                           row_idx;
  logic [DIM-1:0][BITS-1:0]             row_data;
  logic [DIM-1:0]                       col_mask;
  logic                                 busy;
  logic                                 done;
  logic                                 cfg_err;

  int n_checks = 0;
  int n_errs   = 0;

  layoutb_stream_ctrl #(.BITS(BITS), .DIM(DIM), .DRAIN(DRAIN_C)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .n         (n),
    .p         (p),
    .OUTB      (OUTB),
    .stall     (stall),
    .cap_en    (cap_en),
    .row_valid (row_valid),
    .row_idx   (row_idx),
    .row_data  (row_data),
    .col_mask  (col_mask),
    .busy      (busy),
    .done      (done),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [255:0] exp_row(input int idx, input int pp);
    logic [255:0] r;
    r = '0;
    for (int c = 0; c < DIM; c++) begin
      if (c < pp) r[c*BITS +: BITS] = OUTB[idx][c];
    end
    return r;
  endfunction

  function automatic logic [31:0] exp_mask(input int pp);
    logic [31:0] m;
    m = '0;
    for (int c = 0; c < DIM; c++) begin
      if (c < pp) m[c] = 1'b1;
    end
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete run. s0/s1: wavefront indices whose issue cycle is stalled
  // for 2 cycles (-1 = none). poke: pulse start in STREAM and in DONE.
  task automatic run(input int nn, input int pp, input int s0, input int s1, input bit poke);
    int  last;
    int  nst;
    int  exp_done;
    int  issue;
    int  stalled;
    int  hold;
    bit  rv_prev;
    last    = nn + pp - 2;
    nst     = 0;
    issue   = 0;
    stalled = 0;
    hold    = -1;
    rv_prev = 1'b0;
    if (s0 >= 0 && s0 <= last) nst += 2;
    if (s1 >= 0 && s1 <= last && s1 != s0) nst += 2;
    // LOAD=1, first issue=2, last issue=2+last+nst, DRAIN+1 drain cycles, DONE.
    exp_done = 2 + last + nst + DRAIN_C + 2;
    for (int r = 0; r < 2*DIM-1; r++)
      for (int c = 0; c < DIM; c++)
        OUTB[r][c] = 8'($urandom);
    n = 6'(nn);
    p = 6'(pp);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc <= exp_done + 3; cyc++) begin
      chk("ctl{rv,done,busy,cap,cfg}", {row_valid, done, busy, cap_en, cfg_err},
          {rv_prev, (cyc == exp_done), (cyc <= exp_done), (cyc == 1), 1'b0});
      if (rv_prev) begin
        chk("row_idx", row_idx, hold);
        chk("row_data", row_data, exp_row(hold, pp));
      end else if (hold >= 0 && issue <= last) begin
        chk("hold_idx", row_idx, hold);
        chk("hold_data", row_data, exp_row(hold, pp));
      end
      if (cyc == 2) chk("col_mask", col_mask, exp_mask(pp));
      stall = 1'b0;
      start = (poke && (cyc == 4 || cyc == exp_done));
      rv_prev = 1'b0;
      if (cyc >= 2 && issue <= last) begin
        if ((issue == s0 || issue == s1) && stalled < 2) begin
          stall = 1'b1;
          stalled++;
        end else begin
          rv_prev = 1'b1;
          hold    = issue;
          issue++;
          stalled = 0;
        end
      end
      tick();
    end
    start = 1'b0;
    stall = 1'b0;
    chk("issued_count", issue, last + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not end, got running expected finished");
    $fatal(1);
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    n     = '0;
    p     = '0;
    OUTB  = '0;
    repeat (3) tick();
    chk("rst_ctl", {cap_en, row_valid, busy, done, cfg_err, row_idx, col_mask}, '0);
    chk("rst_data", row_data, '0);
    rst = 1'b0;
    tick();

    run(5, 5, -1, -1, 1'b0);
    run(32, 14, 3, 44, 1'b0);
    run(1, 1, -1, -1, 1'b0);
    run(32, 32, -1, -1, 1'b0);

    // Illegal configurations
    n = 6'd0; p = 6'd5; start = 1'b1;
    tick();
    start = 1'b0;
    chk("cfg_n0", {cfg_err, busy, cap_en, row_valid}, 4'b1000);
    tick();
    chk("cfg_n0_clr", {cfg_err, busy, cap_en, row_valid}, 4'b0000);
    n = 6'd33; p = 6'd5; start = 1'b1;
    tick();
    start = 1'b0;
    chk("cfg_n33", {cfg_err, busy, cap_en, row_valid}, 4'b1000);
    tick();
    chk("cfg_n33_clr", {cfg_err, busy, cap_en, row_valid}, 4'b0000);
    n = 6'd5; p = 6'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("cfg_p0", {cfg_err, busy, cap_en, row_valid}, 4'b1000);
    tick();

    // start during STREAM and in the DONE cycle is ignored
    run(4, 7, -1, -1, 1'b1);

    // Reset in the middle of STREAM (idx=5)
    n = 6'd5; p = 6'd5; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    chk("pre_rst_idx", {busy, row_valid, row_idx}, {1'b1, 1'b1, 6'd4});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("post_rst", {row_valid, busy, done, cap_en}, 4'b0000);
    for (int i = 0; i < 10; i++) begin
      chk("post_rst_quiet", {done, busy}, 2'b00);
      tick();
    end
    run(5, 5, 0, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
